// File: rtl/instr_fetch_unit.sv
// Fetch and sequencing stage of the single-cycle MIPS core: holds the PC, splits the
// fetched word into decode fields and sequences run / single-step / halt.
module instr_fetch_unit #(
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        imem_data,
  input  logic               Jump,
  input  logic               Branch,
  input  logic               Zero,
  input  logic               en,
  input  logic               step_mode,
  input  logic               step,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        PC,
  output logic [31:0]        PCPlus4,
  output logic [5:0]         OP,
  output logic [5:0]         Funct,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [31:0]        SignImm,
  output logic               commit,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_reg;
  logic [31:0]       pc_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              step_prev_reg;
  logic              halted_reg;

  logic [31:0]       pc_branch;
  logic [31:0]       pc_jump;
  logic [31:0]       pc_next;
  logic              legal;
  logic              step_rise;
  logic              step_ok;
  logic              advance;

  assign PC          = pc_reg;
  assign PCPlus4     = pc_reg + 32'd4;
  assign imem_addr   = pc_reg[IMEM_AW+1:2];
  assign OP          = imem_data[31:26];
  assign Funct       = imem_data[5:0];
  assign rs          = imem_data[25:21];
  assign rt          = imem_data[20:16];
  assign rd          = imem_data[15:11];
  assign SignImm     = {{16{imem_data[15]}}, imem_data[15:0]};
  assign halted      = halted_reg;
  assign instr_count = count_reg;

  assign pc_branch = PCPlus4 + {SignImm[29:0], 2'b00};
  assign pc_jump   = {PCPlus4[31:28], imem_data[25:0], 2'b00};

  always_comb begin
    pc_next = PCPlus4;
    if (Jump)
      pc_next = pc_jump;
    else if (Branch && Zero)
      pc_next = pc_branch;
  end

  // Only the opcodes the downstream decoder implements; anything else halts the core.
  always_comb begin
    legal = 1'b0;
    case (OP)
      6'b000000: begin
        case (Funct)
          6'b100000, 6'b100010, 6'b100100,
          6'b100101, 6'b100111, 6'b101010: legal = 1'b1;
          default:                         legal = 1'b0;
        endcase
      end
      6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign step_rise = step & ~step_prev_reg;
  assign step_ok   = step_mode ? step_rise : 1'b1;
  assign advance   = (state_reg == RUN) & en & legal & step_ok;
  // Reset must suppress architectural writes even before the first clock edge.
  assign commit    = advance & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= RUN;
      pc_reg        <= RESET_PC;
      count_reg     <= '0;
      step_prev_reg <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      step_prev_reg <= step;
      case (state_reg)
        RUN: begin
          if (advance) begin
            pc_reg <= pc_next;
            if (count_reg != {CNT_W{1'b1}})
              count_reg <= count_reg + CNT_W'(1);
          end else if (en && !legal && step_ok) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end
        end
        HALT: begin
          halted_reg <= 1'b1;
        end
        default: begin
          state_reg  <= HALT;
          halted_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for the sequencing path plus
// hand sequences for reset, step-mode halt, counter saturation and PC wrap.
module tb_instr_fetch_unit;

  localparam logic [31:0] ADD = 32'h0022_1820;
  localparam logic [31:0] BEQ = 32'h1000_FFFE;
  localparam logic [31:0] JMP = 32'h0800_0040;
  localparam logic [31:0] ILL = 32'hFC00_0000;
  localparam logic [31:0] LW  = 32'h8C8A_FFF0;

  logic        clk = 1'b0;
  logic        rst, Jump, Branch, Zero, en, step_mode, step;
  logic [31:0] imem_data;
  logic [5:0]  imem_addr;
  logic [31:0] PC, PCPlus4, SignImm;
  logic [5:0]  OP, Funct;
  logic [4:0]  rs, rt, rd;
  logic        commit, halted;
  logic [15:0] instr_count;

  logic        rst2;
  logic [5:0]  imem_addr2;
  logic [31:0] PC2, PCPlus4_2, SignImm2;
  logic [5:0]  OP2, Funct2;
  logic [4:0]  rs2, rt2, rd2;
  logic        commit2, halted2;
  logic [3:0]  instr_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_data(imem_data), .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .en(en), .step_mode(step_mode), .step(step), .imem_addr(imem_addr), .PC(PC),
    .PCPlus4(PCPlus4), .OP(OP), .Funct(Funct), .rs(rs), .rt(rt), .rd(rd), .SignImm(SignImm),
    .commit(commit), .halted(halted), .instr_count(instr_count)
  );

  instr_fetch_unit #(.IMEM_AW(6), .RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .imem_data(ADD), .Jump(1'b0), .Branch(1'b0), .Zero(1'b0),
    .en(1'b1), .step_mode(1'b0), .step(1'b0), .imem_addr(imem_addr2), .PC(PC2),
    .PCPlus4(PCPlus4_2), .OP(OP2), .Funct(Funct2), .rs(rs2), .rt(rt2), .rd(rd2),
    .SignImm(SignImm2), .commit(commit2), .halted(halted2), .instr_count(instr_count2)
  );

  typedef struct {
    logic [31:0] instr;
    logic        j, b, z, en, sm, st;
    logic        exp_commit;
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;
    logic        exp_halted;
  } vec_t;

  vec_t vq[$];

  function automatic void addv(logic [31:0] instr, logic j, logic b, logic z, logic e,
                               logic sm, logic st, logic cm, logic [31:0] pc,
                               logic [15:0] cnt, logic hl);
    vec_t v;
    v.instr = instr; v.j = j; v.b = b; v.z = z; v.en = e; v.sm = sm; v.st = st;
    v.exp_commit = cm; v.exp_pc = pc; v.exp_cnt = cnt; v.exp_halted = hl;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("commit_in_reset", {31'b0, commit}, 32'd0);
    tick();
    chk("reset_pc", PC, 32'h0);
    chk("reset_cnt", {16'b0, instr_count}, 32'd0);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    imem_data = ADD; Jump = 0; Branch = 0; Zero = 0; en = 1; step_mode = 0; step = 0;
    tick();
    do_reset();

    //    instr j b z en sm st | commit pc            cnt  halted
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h004, 16'd1,  0);
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h008, 16'd2,  0);
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h00C, 16'd3,  0);
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h010, 16'd4,  0);
    addv(BEQ, 0,1,1, 1, 0,0,  1, 32'h00C, 16'd5,  0);
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h010, 16'd6,  0);
    addv(BEQ, 0,1,0, 1, 0,0,  1, 32'h014, 16'd7,  0);
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h018, 16'd8,  0);
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h01C, 16'd9,  0);
    addv(ADD, 0,0,0, 1, 0,0,  1, 32'h020, 16'd10, 0);
    addv(JMP, 1,0,0, 1, 0,0,  1, 32'h100, 16'd11, 0);
    addv(JMP, 1,1,1, 1, 0,0,  1, 32'h100, 16'd12, 0);
    addv(ADD, 0,0,0, 0, 0,0,  0, 32'h100, 16'd12, 0);
    addv(ADD, 0,0,0, 1, 1,0,  0, 32'h100, 16'd12, 0);
    addv(ADD, 0,0,0, 1, 1,1,  1, 32'h104, 16'd13, 0);
    addv(ADD, 0,0,0, 1, 1,1,  0, 32'h104, 16'd13, 0);
    addv(ADD, 0,0,0, 1, 1,1,  0, 32'h104, 16'd13, 0);
    addv(ADD, 0,0,0, 1, 1,0,  0, 32'h104, 16'd13, 0);
    addv(ADD, 0,0,0, 0, 1,1,  0, 32'h104, 16'd13, 0);
    addv(ADD, 0,0,0, 1, 1,1,  0, 32'h104, 16'd13, 0);
    addv(ADD, 0,0,0, 1, 1,0,  0, 32'h104, 16'd13, 0);
    addv(ADD, 0,0,0, 1, 1,1,  1, 32'h108, 16'd14, 0);
    addv(ADD, 0,0,0, 1, 0,1,  1, 32'h10C, 16'd15, 0);
    addv(ILL, 0,0,0, 1, 0,0,  0, 32'h10C, 16'd15, 1);
    addv(ADD, 0,0,0, 0, 0,0,  0, 32'h10C, 16'd15, 1);
    addv(ADD, 0,0,0, 1, 0,0,  0, 32'h10C, 16'd15, 1);

    for (int i = 0; i < vq.size(); i++) begin
      imem_data = vq[i].instr; Jump = vq[i].j; Branch = vq[i].b; Zero = vq[i].z;
      en = vq[i].en; step_mode = vq[i].sm; step = vq[i].st;
      #1;
      chk($sformatf("v%0d_commit", i), {31'b0, commit}, {31'b0, vq[i].exp_commit});
      tick();
      chk($sformatf("v%0d_pc", i), PC, vq[i].exp_pc);
      chk($sformatf("v%0d_cnt", i), {16'b0, instr_count}, {16'b0, vq[i].exp_cnt});
      chk($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, vq[i].exp_halted});
    end
    chk("imem_addr_wrap", {26'b0, imem_addr}, 32'h3);

    // Reset out of HALT
    Jump = 0; Branch = 0; Zero = 0; en = 1; step_mode = 0; step = 0; imem_data = ADD;
    do_reset();

    // Field split, then a mid-run reset
    imem_data = LW;
    #1;
    chk("op", {26'b0, OP}, 32'h23);
    chk("rs", {27'b0, rs}, 32'h04);
    chk("rt", {27'b0, rt}, 32'h0A);
    chk("rd", {27'b0, rd}, 32'h1F);
    chk("funct", {26'b0, Funct}, 32'h30);
    chk("signimm", SignImm, 32'hFFFF_FFF0);
    chk("pcplus4", PCPlus4, 32'h4);
    tick();
    tick();
    chk("midrun_pc", PC, 32'h8);
    chk("midrun_cnt", {16'b0, instr_count}, 32'd2);
    do_reset();

    // Illegal word in step mode only halts on a step edge
    step_mode = 1; step = 0; imem_data = ILL;
    tick();
    chk("step_ill_wait", {31'b0, halted}, 32'd0);
    step = 1;
    #1;
    chk("step_ill_commit", {31'b0, commit}, 32'd0);
    tick();
    chk("step_ill_halted", {31'b0, halted}, 32'd1);
    chk("step_ill_pc", PC, 32'h0);
    step = 0; step_mode = 0; imem_data = ADD;
    do_reset();

    // Second instance: PC wrap from 0xFFFFFFFC and 4-bit counter saturation
    rst2 = 1'b0;
    tick();
    chk("w_reset_pc", PC2, 32'hFFFF_FFFC);
    rst2 = 1'b1;
    #1;
    chk("w_pcplus4", PCPlus4_2, 32'h0);
    chk("w_commit", {31'b0, commit2}, 32'd1);
    tick();
    chk("w_pc_wrap", PC2, 32'h0);
    for (int i = 1; i < 15; i++) tick();
    chk("w_cnt15", {28'b0, instr_count2}, 32'd15);
    for (int i = 15; i < 20; i++) tick();
    chk("w_cnt_sat", {28'b0, instr_count2}, 32'd15);
    chk("w_pc20", PC2, 32'h4C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch and sequencing stage of the single-cycle MIPS core; sits directly upstream of the control decoder.
- Holds the program counter, addresses instruction memory and splits the fetched word into OP/Funct/rs/rt/rd/imm for decode and datapath.
- Computes the next PC from the decoder's Jump/Branch and the ALU Zero flag.
- Provides run / single-step / halt sequencing, a commit strobe that gates architectural writes, and a retired-instruction counter for the board display.

Parameters:
- IMEM_AW, 6, instruction memory word-address width (64 words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- imem_data  in  32  instruction word at imem_addr; combinational read.
- Jump  in  1  from decoder.
- Branch  in  1  from decoder.
- Zero  in  1  from ALU.
- en  in  1  run enable; 0 = stall.
- step_mode  in  1  1 = single-step mode.
- step  in  1  step request, already debounced and synchronous; level signal.
- imem_addr  out  IMEM_AW  PC[IMEM_AW+1:2].
- PC  out  32  current PC.
- PCPlus4  out  32  PC+4.
- OP  out  6  imem_data[31:26].
- Funct  out  6  imem_data[5:0].
- rs  out  5  imem_data[25:21].
- rt  out  5  imem_data[20:16].
- rd  out  5  imem_data[15:11].
- SignImm  out  32  sign-extended imem_data[15:0].
- commit  out  1  current instruction executes this cycle; datapath ANDs it into RegWrite/MemWrite.
- halted  out  1  illegal instruction encountered.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset: rst=0 at a rising edge sets PC=RESET_PC, state=RUN, halted=0, instr_count=0, step_prev=0. Reset overrides every other input and is valid mid-operation, including from HALT.
- While rst=0, commit is forced to 0 combinationally.
- Field outputs (OP, Funct, rs, rt, rd, SignImm, imem_addr) are pure combinational functions of imem_data and PC; zero latency.
- Arithmetic (32-bit modulo 2^32, wrap silently):
  - PCPlus4 = PC+4.
  - PCBranch = PCPlus4 + (SignImm<<2).
  - PCJump = {PCPlus4[31:28], imem_data[25:0], 2'b00}.
- Next-PC priority: Jump > (Branch & Zero) > PCPlus4.
- legal = 1 iff one of:
  - OP=000000 and Funct in {100000, 100010, 100100, 100101, 100111, 101010};
  - OP in {001000, 100011, 101011, 000100, 000010}.
- step_rise = step & ~step_prev; step_prev <= step every cycle (except during reset).
- advance = (state==RUN) & en & legal & (step_mode ? step_rise : 1).
- commit = advance.
- FSM states RUN, HALT:
  - RUN & advance: PC <= next PC; instr_count <= instr_count+1, saturating at all-ones.
  - RUN & en & ~legal: go to HALT. In step_mode, the transition also requires step_rise. PC holds; the instruction is not counted; commit=0.
  - RUN & ~en, or RUN & step_mode & ~step_rise: PC and count hold; commit=0.
  - HALT: halted=1; PC, count frozen; commit=0; only reset leaves.
- halted is registered: it is 1 in the cycle after the illegal word is seen and is equal to (state==HALT).
- step_mode changes take effect in the same cycle. A step held high yields exactly one advance.
- PC wrap: 32'hFFFF_FFFC + 4 -> 0. imem_addr wraps modulo 2^IMEM_AW words.

Test Plan:
- Reset, en=1, step_mode=0, memory holds ADD words -> PC 0,4,8,12 on successive edges; commit=1 each cycle; instr_count=3 after three edges. Pulse rst=0 mid-run -> PC=0, count=0 on the next edge.
- BEQ 0x1000FFFE at PC=0x10 with Branch=1, Zero=1 -> PC=0x0C. Same with Zero=0 -> PC=0x14.
- J 0x08000040 at PC=0x20, Jump=1 -> PC=0x100. Jump=1 together with Branch=1, Zero=1 -> Jump wins.
- Word 0xFC000000 at PC=0x8 -> commit=0; next edge: halted=1, PC stays 0x8, count unchanged, even with en toggling. rst=0 -> halted=0, PC=0.
- step_mode=1, step held high for 5 cycles -> exactly one advance (PC 0->4). Release then reassert -> PC=8. en=0 during a step edge -> no advance.
- CNT_W=4, run 20 legal instructions -> instr_count saturates at 15. Force PC=0xFFFFFFFC with an ADD word -> next PC=0.
